// File: rtl/uart_cmd_ctrl_if.sv
// Byte-stream input, command output and error pulses of the UART command frame controller.
// The master side drives rx_data/rx_vld and cmd_rdy; the slave side is the frame controller.
interface uart_cmd_ctrl_if;
    logic [7:0]  rx_data;
    logic        rx_vld;
    logic [7:0]  cmd_code;
    logic [15:0] cmd_data;
    logic        cmd_vld;
    logic        cmd_rdy;
    logic        err_chk;
    logic        err_ovf;
    logic        err_tmo;
    logic [2:0]  dbg_state;

    // Handshake: a command transfers at a rising clk edge where cmd_vld & cmd_rdy are both 1.
    // cmd_vld, once high, stays high with stable cmd_code/cmd_data until that transfer.
    // rx_vld is a single-cycle strobe with no back-pressure.
    modport master (
        output rx_data, rx_vld, cmd_rdy,
        input  cmd_code, cmd_data, cmd_vld, err_chk, err_ovf, err_tmo, dbg_state
    );

    modport slave (
        input  rx_data, rx_vld, cmd_rdy,
        output cmd_code, cmd_data, cmd_vld, err_chk, err_ovf, err_tmo, dbg_state
    );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// Assembles 5-byte frames (HEAD CMD DATA_H DATA_L CHK), checks the sum and hands out commands.
// Optional inter-byte timeout is enabled by defining UART_CMD_TIMEOUT_EN.
module uart_cmd_ctrl #(
    parameter logic [7:0] HEAD = 8'hA5
`ifdef UART_CMD_TIMEOUT_EN
    , parameter int TIMEOUT = 52080
`endif
) (
    input  logic            clk,
    input  logic            rst,
    uart_cmd_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CMD  = 3'd1,
        S_DH   = 3'd2,
        S_DL   = 3'd3,
        S_CHK  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cmd_sh_q, dh_sh_q, dl_sh_q;
    logic [7:0]  cmd_code_q;
    logic [15:0] cmd_data_q;
    logic        cmd_vld_q, cmd_vld_d;
    logic        err_chk_q, err_ovf_q, err_tmo_q;

    logic        tmo_hit;
    logic [7:0]  sum;
    logic        frame_end, chk_ok, load_cmd, drop_ovf, bad_chk;

`ifdef UART_CMD_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
    logic [15:0] tmo_cnt_q;

    // Counts idle cycles between bytes of a partial frame; a byte on the same cycle wins.
    always_ff @(posedge clk) begin
        if (rst || state_q == S_IDLE || bus.rx_vld || tmo_hit) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_q + 16'd1;
        end
    end

    assign tmo_hit = (state_q != S_IDLE) && !bus.rx_vld && (tmo_cnt_q == TMO_LAST);
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.rx_vld) begin
            case (state_q)
                S_IDLE:  if (bus.rx_data == HEAD) state_d = S_CMD;
                S_CMD:   state_d = S_DH;
                S_DH:    state_d = S_DL;
                S_DL:    state_d = S_CHK;
                S_CHK:   state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end else if (tmo_hit) begin
            state_d = S_IDLE;
        end
    end

    always_comb begin
        sum       = cmd_sh_q + dh_sh_q + dl_sh_q;
        frame_end = bus.rx_vld && (state_q == S_CHK);
        chk_ok    = (bus.rx_data == sum);
        load_cmd  = frame_end && chk_ok && (!cmd_vld_q || bus.cmd_rdy);
        drop_ovf  = frame_end && chk_ok && cmd_vld_q && !bus.cmd_rdy;
        bad_chk   = frame_end && !chk_ok;
        cmd_vld_d = load_cmd || (cmd_vld_q && !bus.cmd_rdy);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_sh_q   <= '0;
            dh_sh_q    <= '0;
            dl_sh_q    <= '0;
            cmd_code_q <= '0;
            cmd_data_q <= '0;
            cmd_vld_q  <= 1'b0;
            err_chk_q  <= 1'b0;
            err_ovf_q  <= 1'b0;
            err_tmo_q  <= 1'b0;
        end else begin
            if (bus.rx_vld && state_q == S_CMD) cmd_sh_q <= bus.rx_data;
            if (bus.rx_vld && state_q == S_DH)  dh_sh_q  <= bus.rx_data;
            if (bus.rx_vld && state_q == S_DL)  dl_sh_q  <= bus.rx_data;
            if (load_cmd) begin
                cmd_code_q <= cmd_sh_q;
                cmd_data_q <= {dh_sh_q, dl_sh_q};
            end
            cmd_vld_q <= cmd_vld_d;
            err_chk_q <= bad_chk;
            err_ovf_q <= drop_ovf;
            err_tmo_q <= tmo_hit;
        end
    end

    assign bus.cmd_code  = cmd_code_q;
    assign bus.cmd_data  = cmd_data_q;
    assign bus.cmd_vld   = cmd_vld_q;
    assign bus.err_chk   = err_chk_q;
    assign bus.err_ovf   = err_ovf_q;
    assign bus.err_tmo   = err_tmo_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed frame stimulus with an expected-event queue checked by a free-running monitor.
module tb_uart_cmd_ctrl;
    localparam int EV_W = 26;
    localparam logic [1:0] EV_CMD = 2'd0;
    localparam logic [1:0] EV_CHK = 2'd1;
    localparam logic [1:0] EV_OVF = 2'd2;
    localparam logic [1:0] EV_TMO = 2'd3;

    logic clk;
    logic rst;
    uart_cmd_ctrl_if bus ();

`ifdef UART_CMD_TIMEOUT_EN
    uart_cmd_ctrl #(.HEAD(8'hA5), .TIMEOUT(100)) dut (.clk(clk), .rst(rst), .bus(bus));
`else
    uart_cmd_ctrl #(.HEAD(8'hA5)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    logic [EV_W-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    logic        prev_vld  = 1'b0;
    logic        prev_rdy  = 1'b0;
    logic [23:0] prev_cmd  = '0;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    task automatic pop_cmp(input string name, input logic [EV_W-1:0] got);
        logic [EV_W-1:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL %s: unexpected event %h with empty queue at %0t", name, got, $time);
        end else begin
            e = exp_q.pop_front();
            check(name, 32'(got), 32'(e));
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (32'(bus.err_chk) + 32'(bus.err_ovf) + 32'(bus.err_tmo) > 1)
                check("err_exclusive", {29'd0, bus.err_chk, bus.err_ovf, bus.err_tmo}, 32'd0);
            if (bus.err_chk) pop_cmp("err_chk", {EV_CHK, 24'd0});
            if (bus.err_ovf) pop_cmp("err_ovf", {EV_OVF, 24'd0});
            if (bus.err_tmo) pop_cmp("err_tmo", {EV_TMO, 24'd0});
            if (prev_vld && !prev_rdy && bus.cmd_vld)
                check("held_stable", {8'd0, bus.cmd_code, bus.cmd_data}, {8'd0, prev_cmd});
            if (bus.cmd_vld && bus.cmd_rdy) pop_cmp("cmd", {EV_CMD, bus.cmd_code, bus.cmd_data});
            prev_vld = bus.cmd_vld;
            prev_rdy = bus.cmd_rdy;
            prev_cmd = {bus.cmd_code, bus.cmd_data};
        end else begin
            prev_vld = 1'b0;
            prev_rdy = 1'b0;
        end
    end

    // driver tasks
    task automatic send_byte(input logic [7:0] b);
        bus.rx_data = b;
        bus.rx_vld  = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_vld  = 1'b0;
        bus.rx_data = 8'h00;
    endtask

    task automatic send_frame(input logic [7:0] b1, input logic [7:0] b2,
                              input logic [7:0] b3, input logic [7:0] b4);
        send_byte(8'hA5);
        send_byte(b1);
        send_byte(b2);
        send_byte(b3);
        send_byte(b4);
    endtask

    task automatic push_cmd(input logic [7:0] code, input logic [15:0] data);
        exp_q.push_back({EV_CMD, code, data});
    endtask

    task automatic push_err(input logic [1:0] kind);
        exp_q.push_back({kind, 24'd0});
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        check(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        rst         = 1'b1;
        bus.rx_data = 8'h00;
        bus.rx_vld  = 1'b0;
        bus.cmd_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_state", 32'(bus.dbg_state), 32'd0);
        check("rst_outputs", {bus.cmd_vld, bus.err_chk, bus.err_ovf, bus.err_tmo,
                              4'd0, bus.cmd_code, bus.cmd_data}, 32'd0);

        // 1: basic frame, latency one cycle, drops next cycle
        bus.cmd_rdy = 1'b1;
        push_cmd(8'h01, 16'h1234);
        send_frame(8'h01, 8'h12, 8'h34, 8'h47);
        check("t1_vld_rise", 32'(bus.cmd_vld), 32'd1);
        check("t1_state_idle", 32'(bus.dbg_state), 32'd0);
        @(posedge clk);
        #1;
        check("t1_vld_fall", 32'(bus.cmd_vld), 32'd0);
        wait_drain("t1_drain");

        // 2: bad checksum, then good frame
        push_err(EV_CHK);
        send_frame(8'h02, 8'h00, 8'h10, 8'h00);
        check("t2_vld_low", 32'(bus.cmd_vld), 32'd0);
        push_cmd(8'h02, 16'h0010);
        send_frame(8'h02, 8'h00, 8'h10, 8'h12);
        wait_drain("t2_drain");

        // 3: overflow while a command is pending
        bus.cmd_rdy = 1'b0;
        send_frame(8'h01, 8'h00, 8'h01, 8'h02);
        push_err(EV_OVF);
        send_frame(8'h03, 8'h00, 8'h05, 8'h08);
        repeat (3) @(posedge clk);
        #1;
        check("t3_held", {bus.cmd_vld, 7'd0, bus.cmd_code, bus.cmd_data}, 32'h8001_0001);
        push_cmd(8'h01, 16'h0001);
        bus.cmd_rdy = 1'b1;
        @(posedge clk);
        #1;
        check("t3_vld_drop", 32'(bus.cmd_vld), 32'd0);
        wait_drain("t3_drain");

        // 4: noise before header, checksum wraparound
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h34);
        check("t4_noise_idle", 32'(bus.dbg_state), 32'd0);
        push_cmd(8'h10, 16'hFFFF);
        send_frame(8'h10, 8'hFF, 8'hFF, 8'h0E);
        wait_drain("t4_drain");

        // HEAD value inside a frame is plain data
        push_cmd(8'hA5, 16'hA5A5);
        send_frame(8'hA5, 8'hA5, 8'hA5, 8'hEF);
        wait_drain("t_head_data");

        // Pending command taken on the same edge a new good frame loads
        bus.cmd_rdy = 1'b0;
        send_frame(8'h07, 8'h00, 8'h01, 8'h08);
        push_cmd(8'h07, 16'h0001);
        push_cmd(8'h08, 16'h0002);
        send_byte(8'hA5);
        send_byte(8'h08);
        send_byte(8'h00);
        send_byte(8'h02);
        bus.cmd_rdy = 1'b1;
        send_byte(8'h0A);
        check("t_swap_vld", {bus.cmd_vld, 7'd0, bus.cmd_code, bus.cmd_data}, 32'h8008_0002);
        wait_drain("t_swap_drain");

`ifdef UART_CMD_TIMEOUT_EN
        // 5: inter-byte timeout
        send_byte(8'hA5);
        send_byte(8'h01);
        push_err(EV_TMO);
        repeat (102) @(posedge clk);
        #1;
        check("t5_state_idle", 32'(bus.dbg_state), 32'd0);
        wait_drain("t5_tmo");
        push_cmd(8'h01, 16'h1234);
        send_frame(8'h01, 8'h12, 8'h34, 8'h47);
        wait_drain("t5_after");
`endif

        // 6: reset mid-frame discards the partial frame
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h12);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("t6_rst_state", 32'(bus.dbg_state), 32'd0);
        send_byte(8'h34);
        send_byte(8'h47);
        check("t6_no_vld", 32'(bus.cmd_vld), 32'd0);
        wait_drain("t6_quiet");
        push_cmd(8'h01, 16'h1234);
        send_frame(8'h01, 8'h12, 8'h34, 8'h47);
        wait_drain("t6_after");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
